fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It sits directly upstream of the load-use/branch interlock: it feeds ifid_ir (rs/rt/opcode fields) to the interlock and consumes its stall output. On stall it freezes the PC and IF/ID and requests a bubble into ID/EX. On a taken branch it redirects the PC and flushes the wrong-path instruction. It talks to instruction memory over a request/valid handshake with variable latency.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP, 32'h0000_0000, instruction word injected on bubble/flush (sll $0,$0,0)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
stall  in  1  from interlock; hold PC and IF/ID this cycle
branch_taken  in  1  branch resolved taken in ID
branch_target  in  32  redirect address, word aligned
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= PC)
imem_rdata  in  32  fetched instruction
imem_valid  in  1  imem_rdata valid this cycle (>=0 cycles after req)
ifid_ir  out  32  IF/ID instruction register
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction
idex_bubble  out  1  load NOP into ID/EX this cycle
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (async, resetn=0): PC=RESET_PC, state=FETCH, ifid_ir=NOP, ifid_pc4=0, ifid_valid=0, holding buffer empty, stall_cycles=0. Outputs take these values immediately, not at the next edge. imem_req=0 while resetn=0. Deassertion is synchronised by the user; the first request is issued in the first cycle after release.
- States: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=PC.
  - imem_valid=1, stall=0, branch_taken=0: ifid_ir<=imem_rdata, ifid_pc4<=PC+4, ifid_valid<=1, PC<=PC+4.
  - imem_valid=1, stall=1: capture imem_rdata and PC+4 into holding buffer, PC<=PC+4, go HOLD. IF/ID unchanged.
  - imem_valid=0, stall=0, branch_taken=0: ifid_ir<=NOP, ifid_valid<=0 (fetch bubble). PC unchanged.
  - imem_valid=0, stall=1: everything held.
- HOLD: imem_req=0, PC not advanced.
  - stall=1: everything held.
  - stall=0, branch_taken=0: IF/ID<=buffer, ifid_valid<=1, go FETCH.
- Branch: branch_taken is honoured only when stall=0. The interlock keeps an unresolved branch stalled, so branch_taken with stall=1 is ignored.
  - When honoured (either state): PC<=branch_target, ifid_ir<=NOP, ifid_valid<=0, buffer dropped, go FETCH. Any imem_valid data that cycle is discarded (single delay-slot-free flush).
- Priority: resetn > branch_taken (when stall=0) > stall > normal advance.
- idex_bubble = stall (combinational, same cycle).
- stall_cycles increments each clock with stall=1. It saturates at all-ones and never wraps.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0. ifid_pc4 wraps identically.
- branch_target[1:0] is ignored; it is treated as 2'b00.

Test Plan:
- Reset release, imem_valid=1 every cycle, words A,B,C -> imem_addr 0,4,8. ifid_ir A,B,C one cycle after each; ifid_pc4 4,8,12; ifid_valid=1 from cycle 2.
- stall=1 for 2 cycles while fetching addr 8 (valid=1) -> IF/ID holds B for 2 cycles, state HOLD, imem_req=0. idex_bubble=1 both cycles. Then ifid_ir=C and ifid_pc4=12, next addr 12. stall_cycles=2.
- branch_taken=1, target 32'h40, with valid data at addr 12 -> addr-12 word discarded, ifid_valid=0, ifid_ir=NOP, next imem_addr=32'h40.
- In HOLD, stall drops and branch_taken=1 in the same cycle -> buffer dropped, PC=target, IF/ID=NOP.
- imem_valid low for 3 cycles at addr 16 -> imem_addr stays 16, IF/ID=NOP with valid=0. Data returns -> ifid_ir loaded, PC=20.
- resetn pulled low mid-HOLD -> outputs return to reset values asynchronously, before the next edge. After release, fetch restarts at RESET_PC. Drive stall=1 for 2^CNT_W+5 cycles -> stall_cycles=all-ones.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Fetches over a request/valid handshake with variable latency. A stall
// freezes the PC and IF/ID. A taken branch redirects the PC and flushes the
// wrong-path instruction. A fetch that completes during a stall is parked
// in a one-entry holding buffer, and it drains into IF/ID when the stall
// releases.
//
//   state | meaning
//   FETCH | request outstanding at PC; IF/ID advances on imem_valid
//   HOLD  | fetched word parked in buffer; no request, waits for stall=0
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      ifid_ir,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q;
    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       pc4_q;
    logic              valid_q;
    logic [31:0]       buf_ir_q;
    logic [31:0]       buf_pc4_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       pc_plus4_d;

    // PC increment (wraps modulo 2^32)
    assign pc_plus4_d = pc_q + 32'd4;

    // Fetch FSM, PC, IF/ID register, holding buffer and stall counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            pc4_q     <= 32'h0000_0000;
            valid_q   <= 1'b0;
            buf_ir_q  <= NOP;
            buf_pc4_q <= 32'h0000_0000;
            cnt_q     <= '0;
        end else begin
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (!stall && branch_taken) begin
                // A stalled branch is still unresolved, so only an unstalled one flushes
                pc_q    <= {branch_target[31:2], 2'b00};
                ir_q    <= NOP;
                valid_q <= 1'b0;
                state_q <= FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (imem_valid) begin
                            pc_q <= pc_plus4_d;
                            if (stall) begin
                                buf_ir_q  <= imem_rdata;
                                buf_pc4_q <= pc_plus4_d;
                                state_q   <= HOLD;
                            end else begin
                                ir_q    <= imem_rdata;
                                pc4_q   <= pc_plus4_d;
                                valid_q <= 1'b1;
                            end
                        end else if (!stall) begin
                            ir_q    <= NOP;
                            valid_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            ir_q    <= buf_ir_q;
                            pc4_q   <= buf_pc4_q;
                            valid_q <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    // Request is gated by reset so nothing is fetched while held in reset
    assign imem_req     = resetn && (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign ifid_ir      = ir_q;
    assign ifid_pc4     = pc4_q;
    assign ifid_valid   = valid_q;
    assign idex_bubble  = stall;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench acts as instruction memory
// and returns a word derived from the fetch address. Every word accepted from
// memory goes into a scoreboard queue, and it is popped and compared when it
// should appear in IF/ID.
module tb_fetch_unit;

    localparam int          CNT_W = 16;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             stall = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_target = '0;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata = '0;
    logic             imem_valid = 1'b0;
    logic [31:0]      ifid_ir;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cycles;

    fetch_unit #(.RESET_PC(32'h0), .NOP(NOP), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .idex_bubble(idex_bubble), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
    } ent_t;

    ent_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Expected-side view of the fetch stage
    logic [31:0]      m_pc;
    bit               m_hold;
    logic [31:0]      m_ir;
    logic [31:0]      m_pc4;
    bit               m_v;
    logic [CNT_W-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA5C3_0001 ^ (a << 4);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_hold = 0; m_ir = NOP; m_pc4 = 32'h0; m_v = 0; m_cnt = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus (called at posedge+1), then check results.
    task automatic cycle(input logic s, input logic br, input logic [31:0] tgt, input logic v);
        logic [31:0] data;
        ent_t        e;
        bit          ld_v;
        bit          ld_n;
        ld_v = 0;
        ld_n = 0;
        data = v ? word(m_pc) : 32'hDEAD_BEEF;
        stall = s; branch_taken = br; branch_target = tgt;
        imem_valid = v; imem_rdata = data;
        #1;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, !m_hold});
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("idex_bubble", {31'b0, idex_bubble}, {31'b0, s});
        if (!s && br) begin
            m_pc = {tgt[31:2], 2'b00};
            m_hold = 0;
            exp_q.delete();
            ld_n = 1;
        end else if (!m_hold) begin
            if (v) begin
                e.ir = data;
                e.pc4 = m_pc + 32'd4;
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
                if (s) m_hold = 1;
                else   ld_v = 1;
            end else if (!s) begin
                ld_n = 1;
            end
        end else if (!s) begin
            m_hold = 0;
            ld_v = 1;
        end
        if (s && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
        @(posedge clock);
        #1;
        if (ld_v) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                m_ir = e.ir; m_pc4 = e.pc4; m_v = 1;
            end
        end
        if (ld_n) begin
            m_ir = NOP; m_v = 0;
        end
        check_eq("ifid_ir", ifid_ir, m_ir);
        check_eq("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
        if (m_v) check_eq("ifid_pc4", ifid_pc4, m_pc4);
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        check_eq({tag, "_addr"},  imem_addr, 32'h0);
        check_eq({tag, "_ir"},    ifid_ir, NOP);
        check_eq({tag, "_pc4"},   ifid_pc4, 32'h0);
        check_eq({tag, "_valid"}, {31'b0, ifid_valid}, 32'd0);
        check_eq({tag, "_cnt"},   32'(stall_cycles), 32'd0);
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Sequential fetch: A@0, B@4
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check_eq("pc4_after_B", ifid_pc4, 32'd8);
        // Stall two cycles while addr 8 returns: C parked, B held
        cycle(1, 0, 0, 1);
        check_eq("hold_ir_B", ifid_ir, word(32'd4));
        cycle(1, 0, 0, 0);
        check_eq("stall_cnt_2", 32'(stall_cycles), 32'd2);
        // Release: C drains from the buffer
        cycle(0, 0, 0, 0);
        check_eq("drain_C", ifid_ir, word(32'd8));
        check_eq("drain_pc4", ifid_pc4, 32'd12);
        // Branch to 0x40 while addr-12 data arrives: discarded
        cycle(0, 1, 32'h40, 1);
        check_eq("flush_addr", imem_addr, 32'h40);
        // Branch with stall=1 is ignored
        cycle(1, 1, 32'h80, 0);
        cycle(0, 0, 0, 1);
        // Stall with valid -> HOLD, then release + branch together
        cycle(1, 0, 0, 1);
        cycle(0, 1, 32'h10, 0);
        check_eq("hold_branch_addr", imem_addr, 32'h10);
        // Memory latency: three empty cycles at 16, then data
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check_eq("late_pc", imem_addr, 32'd20);
        // Low target bits ignored
        cycle(0, 1, 32'h0000_0103, 0);
        check_eq("tgt_align", imem_addr, 32'h100);
        // PC wrap at the top of the address space
        cycle(0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 1);
        check_eq("wrap_pc4", ifid_pc4, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);
        // Enter HOLD, then assert reset between edges
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        #2;
        resetn = 1'b0;
        stall = 0; branch_taken = 0; imem_valid = 0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        check_reset_outputs("rst_held");
        resetn = 1'b1;
        // Fetch restarts at RESET_PC
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        // Long stall: counter saturates
        for (int i = 0; i < (1 << CNT_W) + 5; i++) cycle(1, 0, 0, 0);
        check_eq("cnt_sat", 32'(stall_cycles), 32'(16'hFFFF));
        cycle(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
